multiply_accumulate: RTL and testbench

MULTIPLY_ACCUMULATE -- requirements
Module: multiply_accumulate

---
 rtl/multiply_accumulate_pkg.sv | 18 +
 rtl/multiply_accumulate_if.sv | 34 +++
 rtl/mac_add_sat.sv | 26 ++
 rtl/multiply_accumulate.sv | 112 +++++++++++
 tb/tb_multiply_accumulate.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/multiply_accumulate_pkg.sv
// Shared constants and types for the multiply-accumulate pipeline.
// Optional build macro: MULTIPLY_ACCUMULATE_SAT_EN (saturate instead of wrap).
package multiply_accumulate_pkg;

    localparam int A_W_DEF   = 18;
    localparam int B_W_DEF   = 18;
    localparam int ACC_W_DEF = 48;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_ACC = 1'b1
    } mode_e;

    function automatic bit widths_ok(input int a_w, input int b_w, input int acc_w);
        return acc_w >= a_w + b_w;
    endfunction

endpackage

// File: rtl/multiply_accumulate_if.sv
// Beat-level bus for multiply_accumulate: operand input channel and result output channel.
interface multiply_accumulate_if
    import multiply_accumulate_pkg::*;
#(
    parameter int A_W   = A_W_DEF,
    parameter int B_W   = B_W_DEF,
    parameter int ACC_W = ACC_W_DEF
);
    // Both channels use valid/ready: a beat transfers on a rising edge where
    // valid && ready; the sender holds payload and valid stable until then.
    logic             in_valid;
    logic             in_ready;
    logic [A_W-1:0]   a;
    logic [B_W-1:0]   b;
    logic [ACC_W-1:0] c;
    logic             mode;
    logic             first;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] result;
    logic             overflow;
    logic             ovf_sticky;

    modport slave (
        input  in_valid, a, b, c, mode, first, out_ready,
        output in_ready, out_valid, result, overflow, ovf_sticky
    );

    modport master (
        output in_valid, a, b, c, mode, first, out_ready,
        input  in_ready, out_valid, result, overflow, ovf_sticky
    );

endinterface

// File: rtl/mac_add_sat.sv
// Stage-2 adder: base + zero-extended product with carry out.
// With MULTIPLY_ACCUMULATE_SAT_EN defined the result saturates to all-ones on carry.
module mac_add_sat
    import multiply_accumulate_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int PROD_W = A_W_DEF + B_W_DEF
) (
    input  logic [ACC_W-1:0]  base,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  result,
    output logic              overflow
);

    logic [ACC_W:0] sum;

    assign sum      = {1'b0, base} + (ACC_W+1)'(prod);
    assign overflow = sum[ACC_W];

`ifdef MULTIPLY_ACCUMULATE_SAT_EN
    assign result = overflow ? '1 : sum[ACC_W-1:0];
`else
    assign result = sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/multiply_accumulate.sv
// Two-stage multiply-add / running-accumulate pipeline with global stall.
// Optional build macro: MULTIPLY_ACCUMULATE_SAT_EN (saturating result and accumulator).
module multiply_accumulate
    import multiply_accumulate_pkg::*;
#(
    parameter int A_W   = A_W_DEF,
    parameter int B_W   = B_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input logic                 clk,
    input logic                 reset,
    multiply_accumulate_if.slave bus
);

    localparam int PROD_W = A_W + B_W;

    if (!widths_ok(A_W, B_W, ACC_W)) begin : g_width_check
        $error("multiply_accumulate: ACC_W must be >= A_W + B_W");
    end

    logic              adv;
    logic              accept;
    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] b_ext;

    logic              s1_valid;
    logic [PROD_W-1:0] s1_prod;
    logic [ACC_W-1:0]  s1_c;
    mode_e             s1_mode;
    logic              s1_first;

    logic              new_chain;
    logic [ACC_W-1:0]  base;
    logic [ACC_W-1:0]  sum_result;
    logic              sum_ovf;

    logic [ACC_W-1:0]  acc;
    logic              out_valid_q;
    logic [ACC_W-1:0]  result_q;
    logic              overflow_q;
    logic              sticky_q;

    // Whole pipe moves together; only a stalled output beat blocks it.
    assign adv          = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && adv;
    assign bus.in_ready = adv;

    assign a_ext = PROD_W'(bus.a);
    assign b_ext = PROD_W'(bus.b);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            s1_c     <= '0;
            s1_mode  <= MODE_ADD;
            s1_first <= 1'b0;
        end else if (adv) begin
            s1_valid <= bus.in_valid;
            if (accept) begin
                s1_prod  <= a_ext * b_ext;
                s1_c     <= bus.c;
                s1_mode  <= mode_e'(bus.mode);
                s1_first <= bus.first;
            end
        end
    end

    // A mode-0 beat or a first=1 beat starts from c and restarts the sticky flag.
    assign new_chain = (s1_mode == MODE_ADD) || s1_first;
    assign base      = new_chain ? s1_c : acc;

    mac_add_sat #(
        .ACC_W  (ACC_W),
        .PROD_W (PROD_W)
    ) u_add (
        .base     (base),
        .prod     (s1_prod),
        .result   (sum_result),
        .overflow (sum_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            sticky_q    <= 1'b0;
        end else if (adv) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                result_q   <= sum_result;
                overflow_q <= sum_ovf;
                sticky_q   <= new_chain ? sum_ovf : (sticky_q | sum_ovf);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (adv && s1_valid && (s1_mode == MODE_ACC)) begin
            acc <= sum_result;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.result     = result_q;
    assign bus.overflow   = overflow_q;
    assign bus.ovf_sticky = sticky_q;

endmodule

// File: tb/tb_multiply_accumulate.sv
// Scoreboard bench for multiply_accumulate: directed beats, queued expectations, output monitor.
module tb_multiply_accumulate;
    import multiply_accumulate_pkg::*;

    localparam int A_W   = 18;
    localparam int B_W   = 18;
    localparam int ACC_W = 36;
`ifdef MULTIPLY_ACCUMULATE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam logic [ACC_W-1:0] ONES = '1;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [ACC_W-1:0] exp_res_q[$];
    logic [0:0]       exp_ovf_q[$];
    logic [0:0]       exp_st_q[$];

    multiply_accumulate_if #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W)) bus ();

    multiply_accumulate #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Driver: presents one beat, waits for acceptance, optionally records expectation.
    task automatic send(input logic [A_W-1:0] a_v, input logic [B_W-1:0] b_v,
                        input logic [ACC_W-1:0] c_v, input logic mode_v, input logic first_v,
                        input logic [ACC_W-1:0] exp_res, input logic exp_ovf,
                        input logic exp_st, input bit push);
        bit ok;
        int n;
        ok = 1'b0;
        n  = 0;
        bus.in_valid = 1'b1;
        bus.a        = a_v;
        bus.b        = b_v;
        bus.c        = c_v;
        bus.mode     = mode_v;
        bus.first    = first_v;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = bus.in_ready;
            if (ok && push) begin
                exp_res_q.push_back(exp_res);
                exp_ovf_q.push_back(exp_ovf);
                exp_st_q.push_back(exp_st);
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_res_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", 64'(exp_res_q.size()), 64'd0);
    endtask

    // Monitor: compares each transferred output beat against the queue head.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (exp_res_q.size() == 0) begin
                check("unexpected_beat", 64'(bus.result), 64'hDEAD);
            end else begin
                check("result", 64'(bus.result), 64'(exp_res_q.pop_front()));
                check("overflow", 64'(bus.overflow), 64'(exp_ovf_q.pop_front()));
                check("ovf_sticky", 64'(bus.ovf_sticky), 64'(exp_st_q.pop_front()));
            end
        end
    end

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.c        = '0;
        bus.mode     = 1'b0;
        bus.first    = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_overflow", 64'(bus.overflow), 64'd0);
        check("rst_sticky", 64'(bus.ovf_sticky), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Mode 0 basic with latency check
        send(18'd3, 18'd5, 36'd10, MODE_ADD, 1'b0, 36'd25, 1'b0, 1'b0, 1'b1);
        check("lat_not_early", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("lat_two_cycles", 64'(bus.out_valid), 64'd1);
        drain();

        // Mode 1 running accumulate, back to back
        send(18'd2, 18'd3, 36'd1, MODE_ACC, 1'b1, 36'd7, 1'b0, 1'b0, 1'b1);
        send(18'd4, 18'd5, 36'd0, MODE_ACC, 1'b0, 36'd27, 1'b0, 1'b0, 1'b1);
        send(18'd1, 18'd1, 36'd0, MODE_ACC, 1'b0, 36'd28, 1'b0, 1'b0, 1'b1);
        drain();

        // Mode 0 overflow at full-scale operands
        send(18'h3FFFF, 18'h3FFFF, ONES, MODE_ADD, 1'b0,
             SAT ? ONES : 36'hF_FFF8_0000, 1'b1, 1'b1, 1'b1);
        drain();

        // Sticky overflow across an accumulation chain, cleared by mode 0 and first=1
        send(18'd1, 18'd1, ONES, MODE_ACC, 1'b1, SAT ? ONES : 36'd0, 1'b1, 1'b1, 1'b1);
        send(18'd1, 18'd1, 36'd0, MODE_ACC, 1'b0, SAT ? ONES : 36'd1, SAT, 1'b1, 1'b1);
        send(18'd2, 18'd3, 36'd0, MODE_ACC, 1'b0, SAT ? ONES : 36'd7, SAT, 1'b1, 1'b1);
        send(18'd1, 18'd1, 36'd0, MODE_ADD, 1'b0, 36'd1, 1'b0, 1'b0, 1'b1);
        send(18'd0, 18'd7, 36'd5, MODE_ACC, 1'b1, 36'd5, 1'b0, 1'b0, 1'b1);
        send(18'd3, 18'd3, 36'd0, MODE_ACC, 1'b0, 36'd14, 1'b0, 1'b0, 1'b1);
        drain();

        // Backpressure: three beats offered while out_ready is low
        bus.out_ready = 1'b0;
        fork
            begin
                send(18'd1, 18'd1, 36'd0, MODE_ADD, 1'b0, 36'd1, 1'b0, 1'b0, 1'b1);
                send(18'd2, 18'd2, 36'd0, MODE_ADD, 1'b0, 36'd4, 1'b0, 1'b0, 1'b1);
                send(18'd3, 18'd3, 36'd0, MODE_ADD, 1'b0, 36'd9, 1'b0, 1'b0, 1'b1);
            end
            begin
                @(posedge clk);
                @(posedge clk);
                #1;
                check("stall_in_ready", 64'(bus.in_ready), 64'd0);
                check("stall_out_valid", 64'(bus.out_valid), 64'd1);
                check("stall_result", 64'(bus.result), 64'd1);
                @(posedge clk);
                #1;
                check("stall_hold_result", 64'(bus.result), 64'd1);
                check("stall_hold_in_ready", 64'(bus.in_ready), 64'd0);
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with mode-1 beats in flight, then a first=0 beat restarts from zero
        send(18'd2, 18'd3, 36'd1, MODE_ACC, 1'b1, 36'd0, 1'b0, 1'b0, 1'b0);
        send(18'd4, 18'd5, 36'd0, MODE_ACC, 1'b0, 36'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_result", 64'(bus.result), 64'd0);
        check("midrst_sticky", 64'(bus.ovf_sticky), 64'd0);
        @(posedge clk);
        #1;
        check("midrst_no_partial", 64'(bus.out_valid), 64'd0);
        send(18'd1, 18'd1, 36'd99, MODE_ACC, 1'b0, 36'd1, 1'b0, 1'b0, 1'b1);
        drain();

        repeat (3) @(posedge clk);
        #1;
        check("final_queue_empty", 64'(exp_res_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
